// File: rtl/fifo_stream_out_if.sv
// Valid/ready word stream between the FIFO read adapter and its consumer.
// The master drives vld/dat; the slave drives rdy.
interface fifo_stream_out_if #(
  parameter int WIDTH = 32
);
  logic             vld;
  logic [WIDTH-1:0] dat;
  logic             rdy;

  modport master (output vld, output dat, input rdy);
  modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/fifo_stream_out.sv
// Pops a synchronous FIFO and re-presents its words on a valid/ready stream via a 2-entry buffer.
// Latency: rd_en in cycle T, word valid on the stream in T+2; one word per cycle sustained.
// Backpressure: with rdy low at most two further pops land (buffer full), then reads stop until rdy returns.
module fifo_stream_out #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_data_i,
  output logic                 fifo_rd_en_o,
  fifo_stream_out_if.master    m,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     beat_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             inflight_q;
  logic             valid_q;
  logic [CNT_W-1:0] beat_q;

  logic             pop;
  logic             push;
  logic             rd_en;
  logic [2:0]       pending;

  assign pop  = valid_q && m.rdy;
  assign push = inflight_q;

  // Words already buffered plus the one still coming back from the FIFO.
  assign pending = {1'b0, state_q} + {2'b00, inflight_q};

  // A read may be issued into the last free slot only if the head leaves this cycle.
  always_comb begin
    rd_en = 1'b0;
    if (rst_i && !fifo_empty_i) begin
      rd_en = (pending < 3'd2) || ((pending == 3'd2) && pop);
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = fifo_data_i;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = fifo_data_i;
        end else if (push) begin
          state_d = TWO;
          tail_d  = fifo_data_i;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Read issue never allows a push here unless the head is leaving.
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = fifo_data_i;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= rd_en;
      valid_q    <= (state_d != EMPTY);
      if (pop) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m.vld        = valid_q;
  assign m.dat        = head_q;
  assign occupancy_o  = state_q;
  assign beat_cnt_o   = beat_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed and table-driven bench for fifo_stream_out with a behavioural FIFO upstream.
// A second instance with a 4-bit beat counter runs in lockstep to exercise counter wrap.
module tb_fifo_stream_out;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          ready;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          rd_en, rd_en4;
  logic [1:0]    occ, occ4;
  logic [15:0]   cnt;
  logic [3:0]    cnt4;

  fifo_stream_out_if #(.WIDTH(W)) s_if ();
  fifo_stream_out_if #(.WIDTH(W)) s4_if ();
  assign s_if.rdy  = ready;
  assign s4_if.rdy = ready;

  fifo_stream_out #(.WIDTH(W), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd_en), .m(s_if), .occupancy_o(occ), .beat_cnt_o(cnt)
  );

  fifo_stream_out #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd_en4), .m(s4_if), .occupancy_o(occ4), .beat_cnt_o(cnt4)
  );

  // Upstream FIFO model: data appears the cycle after a pop.
  logic [W-1:0] mem [0:511];
  int wptr = 0;
  int rptr = 0;
  assign fifo_empty = (wptr == rptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data <= '0;
    end else if (rd_en && !fifo_empty) begin
      fifo_data <= mem[rptr[8:0]];
      rptr      <= rptr + 1;
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   rx_idx = 0;
  int   rx_cnt = 0;
  logic xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] v);
    mem[wptr[8:0]] = v;
    wptr++;
  endtask

  // Advance to the next falling edge, drive ready, then check per-cycle invariants and order.
  task automatic tick(input logic r);
    @(negedge clk);
    ready = r;
    #1;
    xfer = 1'b0;
    if (!rst_n) begin
      rx_idx = rptr;
    end else begin
      chk("no_pop_when_empty", 32'(rd_en && fifo_empty), 32'd0);
      chk("occ_le_2", 32'(occ <= 2'd2), 32'd1);
      chk("vld_iff_occ", 32'(s_if.vld), 32'(occ != 2'd0));
      chk("lockstep", 32'({rd_en4, s4_if.vld, occ4, s4_if.dat == s_if.dat}),
          32'({rd_en, s_if.vld, occ, 1'b1}));
      if (s_if.vld && ready) begin
        chk("order", s_if.dat, mem[rx_idx[8:0]]);
        rx_idx++;
        rx_cnt++;
        xfer = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_vld"},   32'(s_if.vld), 32'd0);
    chk({tag, "_occ"},   32'(occ), 32'd0);
    chk({tag, "_cnt"},   32'(cnt), 32'd0);
    chk({tag, "_dat"},   s_if.dat, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    wptr = rptr;
    tick(1'b0);
    tick(1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rd_en;
    logic        vld;
    logic [1:0]  occ;
    logic [31:0] dat;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec [19];

  task automatic setv(input int i, input logic r, input logic e, input logic v,
                      input logic [1:0] o, input logic [31:0] d, input logic [15:0] c);
    vec[i].rdy = r; vec[i].rd_en = e; vec[i].vld = v;
    vec[i].occ = o; vec[i].dat = d;   vec[i].cnt = c;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, prev, c;

    // Cycle-by-cycle expectations after reset release with 8 words queued:
    // 10 cycles stalled, then ready held high until the buffer drains.
    setv(0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 16'd0);
    setv(1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 16'd0);
    setv(2, 1'b0, 1'b0, 1'b1, 2'd1, 32'h1, 16'd0);
    for (int i = 3; i < 10; i++) setv(i, 1'b0, 1'b0, 1'b1, 2'd2, 32'h1, 16'd0);
    setv(10, 1'b1, 1'b1, 1'b1, 2'd2, 32'h1, 16'd0);
    for (int i = 11; i < 16; i++) setv(i, 1'b1, 1'b1, 1'b1, 2'd1, 32'(i - 9), 16'(i - 10));
    setv(16, 1'b1, 1'b0, 1'b1, 2'd1, 32'h7, 16'd6);
    setv(17, 1'b1, 1'b0, 1'b1, 2'd1, 32'h8, 16'd7);
    setv(18, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 16'd8);

    ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'(i + 1));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk_reset_outputs("reset_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      tick(vec[i].rdy);
      chk("vec_rd_en", 32'(rd_en), 32'(vec[i].rd_en));
      chk("vec_vld",   32'(s_if.vld), 32'(vec[i].vld));
      chk("vec_occ",   32'(occ), 32'(vec[i].occ));
      chk("vec_cnt",   32'(cnt), 32'(vec[i].cnt));
      if (vec[i].vld) chk("vec_dat", s_if.dat, vec[i].dat);
    end

    // Streaming: 16 back-to-back words, counter checked every cycle.
    do_reset();
    for (int i = 0; i < 16; i++) push_word(32'(i + 1));
    rx_cnt = 0;
    first  = -1;
    last   = -1;
    c      = 0;
    while (c < 40 && rx_cnt < 16) begin
      prev = rx_cnt;
      tick(1'b1);
      chk("stream_cnt",  32'(cnt), 32'(prev));
      chk("stream_cnt4", 32'(cnt4), 32'(prev % 16));
      if (xfer) begin
        if (first < 0) first = c;
        last = c;
      end
      c++;
    end
    chk("stream_count", 32'(rx_cnt), 32'd16);
    chk("stream_no_bubble", 32'(last - first), 32'd15);
    tick(1'b1);
    chk("stream_cnt_16", 32'(cnt), 32'd16);
    chk("wrap_cnt4_0",   32'(cnt4), 32'd0);
    push_word(32'h11);
    repeat (5) tick(1'b1);
    chk("stream_cnt_17", 32'(cnt), 32'd17);
    chk("wrap_cnt4_1",   32'(cnt4), 32'd1);

    // Random backpressure with a bursty producer: order and occupancy checked every cycle.
    rx_cnt = 0;
    begin
      int remaining = 200;
      int k = 0;
      for (int n = 0; n < 3000 && rx_cnt < 200; n++) begin
        if (remaining > 0 && $urandom_range(0, 99) < 60) begin
          push_word(32'h1000 + 32'(k));
          k++;
          remaining--;
        end
        tick(1'($urandom_range(0, 1)));
      end
    end
    chk("rand_count", 32'(rx_cnt), 32'd200);

    // Reset with a full buffer; nothing from before the reset may reappear.
    repeat (3) tick(1'b1);
    chk("drained_occ", 32'(occ), 32'd0);
    for (int i = 0; i < 6; i++) push_word(32'hA0 + 32'(i));
    repeat (4) tick(1'b0);
    chk("pre_reset_occ", 32'(occ), 32'd2);
    chk("pre_reset_dat", s_if.dat, 32'hA0);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    wptr = rptr;
    tick(1'b0);
    tick(1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'hB0 + 32'(i));
    rx_cnt = 0;
    repeat (10) tick(1'b1);
    chk("post_reset_count", 32'(rx_cnt), 32'd3);
    chk("post_reset_cnt",   32'(cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
